// File: rtl/reorder_buffer.sv
// rtl/reorder_buffer.sv - in-order retirement buffer: 4-wide dispatch, 2 writeback ports, 1 retire per cycle
module reorder_buffer #(
    parameter int DEPTH = 16,
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Branch_flush,
    input  logic             Inst1_Valid,
    input  logic             Inst1_RegW,
    input  logic [4:0]       Inst1_Rdst,
    input  logic [5:0]       Inst1_RPhydst,
    input  logic             Inst2_Valid,
    input  logic             Inst2_RegW,
    input  logic [4:0]       Inst2_Rdst,
    input  logic [5:0]       Inst2_RPhydst,
    input  logic             Inst3_Valid,
    input  logic             Inst3_RegW,
    input  logic [4:0]       Inst3_Rdst,
    input  logic [5:0]       Inst3_RPhydst,
    input  logic             Inst4_Valid,
    input  logic             Inst4_RegW,
    input  logic [4:0]       Inst4_Rdst,
    input  logic [5:0]       Inst4_RPhydst,
    output logic [IDX_W-1:0] Inst1_Tag,
    output logic [IDX_W-1:0] Inst2_Tag,
    output logic [IDX_W-1:0] Inst3_Tag,
    output logic [IDX_W-1:0] Inst4_Tag,
    output logic             ROB_Stall,
    input  logic             WB1_Valid,
    input  logic [IDX_W-1:0] WB1_Tag,
    input  logic             WB2_Valid,
    input  logic [IDX_W-1:0] WB2_Tag,
    output logic             Commit,
    output logic [5:0]       Commit_Phy,
    output logic [4:0]       Commit_Rdst,
    output logic             ROB_Empty,
    output logic [IDX_W:0]   ROB_Count
);

    // Stall once fewer than four entries are free: count >= DEPTH-3.
    localparam logic [IDX_W:0] STALL_AT = (IDX_W+1)'(DEPTH - 3);

    logic [DEPTH-1:0] r_valid;
    logic [DEPTH-1:0] r_done;
    logic [DEPTH-1:0] r_regw;
    logic [4:0]       r_rdst [DEPTH];
    logic [5:0]       r_phy  [DEPTH];
    logic [IDX_W-1:0] r_head;
    logic [IDX_W-1:0] r_tail;
    logic [IDX_W:0]   r_count;
    logic             r_empty;
    logic             r_commit;
    logic [5:0]       r_commit_phy;
    logic [4:0]       r_commit_rdst;

    logic [3:0]       w_sv;
    logic [3:0]       w_sregw;
    logic [4:0]       w_srdst [4];
    logic [5:0]       w_sphy  [4];
    logic [IDX_W-1:0] w_stag  [4];
    logic [2:0]       w_off1;
    logic [2:0]       w_off2;
    logic [2:0]       w_off3;
    logic [2:0]       w_n;
    logic [2:0]       w_n_eff;
    logic             w_stall;
    logic             w_alloc;
    logic             w_retire;
    logic [IDX_W:0]   w_count_next;

    assign w_sv    = {Inst4_Valid, Inst3_Valid, Inst2_Valid, Inst1_Valid};
    assign w_sregw = {Inst4_RegW, Inst3_RegW, Inst2_RegW, Inst1_RegW};
    assign w_srdst[0] = Inst1_Rdst;
    assign w_srdst[1] = Inst2_Rdst;
    assign w_srdst[2] = Inst3_Rdst;
    assign w_srdst[3] = Inst4_Rdst;
    assign w_sphy[0]  = Inst1_RPhydst;
    assign w_sphy[1]  = Inst2_RPhydst;
    assign w_sphy[2]  = Inst3_RPhydst;
    assign w_sphy[3]  = Inst4_RPhydst;

    // Valid slots are packed in slot order starting at the tail.
    assign w_off1 = {2'b00, w_sv[0]};
    assign w_off2 = w_off1 + {2'b00, w_sv[1]};
    assign w_off3 = w_off2 + {2'b00, w_sv[2]};
    assign w_n    = w_off3 + {2'b00, w_sv[3]};

    assign w_stag[0] = r_tail;
    assign w_stag[1] = r_tail + IDX_W'(w_off1);
    assign w_stag[2] = r_tail + IDX_W'(w_off2);
    assign w_stag[3] = r_tail + IDX_W'(w_off3);

    assign w_stall      = (r_count >= STALL_AT);
    assign w_alloc      = !w_stall;
    assign w_n_eff      = w_alloc ? w_n : 3'd0;
    assign w_retire     = r_valid[r_head] & r_done[r_head];
    assign w_count_next = r_count + (IDX_W+1)'(w_n_eff) - (IDX_W+1)'(w_retire);

    assign Inst1_Tag   = w_stag[0];
    assign Inst2_Tag   = w_stag[1];
    assign Inst3_Tag   = w_stag[2];
    assign Inst4_Tag   = w_stag[3];
    assign ROB_Stall   = w_stall;
    assign Commit      = r_commit;
    assign Commit_Phy  = r_commit_phy;
    assign Commit_Rdst = r_commit_rdst;
    assign ROB_Empty   = r_empty;
    assign ROB_Count   = r_count;

    // Control state: later assignments win, so retire clears any same-cycle writeback to the head.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid       <= '0;
            r_done        <= '0;
            r_head        <= '0;
            r_tail        <= '0;
            r_count       <= '0;
            r_empty       <= 1'b1;
            r_commit      <= 1'b0;
            r_commit_phy  <= '0;
            r_commit_rdst <= '0;
        end else if (Branch_flush) begin
            r_valid  <= '0;
            r_done   <= '0;
            r_head   <= '0;
            r_tail   <= '0;
            r_count  <= '0;
            r_empty  <= 1'b1;
            r_commit <= 1'b0;
        end else begin
            if (WB1_Valid && r_valid[WB1_Tag]) begin
                r_done[WB1_Tag] <= 1'b1;
            end
            if (WB2_Valid && r_valid[WB2_Tag]) begin
                r_done[WB2_Tag] <= 1'b1;
            end
            if (w_retire) begin
                r_valid[r_head] <= 1'b0;
                r_done[r_head]  <= 1'b0;
                r_head          <= r_head + IDX_W'(1);
                r_commit        <= r_regw[r_head];
                r_commit_phy    <= r_phy[r_head];
                r_commit_rdst   <= r_rdst[r_head];
            end else begin
                r_commit <= 1'b0;
            end
            for (int s = 0; s < 4; s++) begin
                if (w_alloc && w_sv[s]) begin
                    r_valid[w_stag[s]] <= 1'b1;
                    r_done[w_stag[s]]  <= 1'b0;
                end
            end
            r_tail  <= r_tail + IDX_W'(w_n_eff);
            r_count <= w_count_next;
            r_empty <= (w_count_next == '0);
        end
    end

    // Payload is qualified by r_valid, so it needs no reset.
    always_ff @(posedge clk) begin
        if (!rst && !Branch_flush) begin
            for (int s = 0; s < 4; s++) begin
                if (w_alloc && w_sv[s]) begin
                    r_regw[w_stag[s]] <= w_sregw[s];
                    r_rdst[w_stag[s]] <= w_srdst[s];
                    r_phy[w_stag[s]]  <= w_sphy[s];
                end
            end
        end
    end

endmodule
